pulse_counter_bank: RTL and testbench
=====================================

# pulse_counter_bank

Parametrised multi-channel pulse edge counter. Each channel counts selected edges on its `i_pulse` bit. An atomic snapshot captures every channel into shadow registers and clears the live counters. A handshake port then streams the captured counts out one channel at a time. It supersedes the fixed 16×16-bit pulse counting top level and sits between the pulse sources and the register/readout logic.

## Interface
Parameters:
- `CH_NUM`, 16: number of channels, ≥1.
- `CNT_W`, 16: counter width per channel, ≥2.
- `SATURATE`, 1: 1 = counters hold at all-ones; 0 = counters wrap to 0.

Ports:
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_pulse`  in  CH_NUM  pulse inputs, one bit per channel.
- `i_en`  in  1  global count enable; when 0, edges are not counted.
- `i_edge_mode`  in  2  00 rising, 01 falling, 10 both, 11 treated as rising.
- `i_snap`  in  1  single-cycle snapshot request.
- `o_busy`  out  1  high in SNAP and STREAM.
- `o_valid`  out  1  stream word valid.
- `i_ready`  in  1  stream word accepted.
- `o_ch`  out  CH_W  channel index of the current word; CH_W = max(1, $clog2(CH_NUM)).
- `o_cnt`  out  CNT_W  captured count.
- `o_ovf`  out  1  captured overflow flag for the channel.

## Operation
- Per channel, a `prev` register holds the previous sample of the pulse bit.
- Edge detection:
  - rise = pulse & ~prev
  - fall = ~pulse & prev
  - Selected edge chosen by `i_edge_mode`, which is sampled every cycle.
- Count update: on a selected edge with `i_en`=1, cnt ← cnt+1.
- At cnt = all-ones:
  - SATURATE=1: cnt holds.
  - SATURATE=0: cnt → 0.
  - In both cases the sticky `ovf` flag sets.
- FSM states: IDLE, SNAP, STREAM.
  - IDLE: when `i_snap`=1, go to SNAP.
  - SNAP (one cycle): shadow_cnt[i] ← cnt[i] and shadow_ovf[i] ← ovf[i] for all channels. The live cnt and ovf are cleared in the same cycle. Index ← 0. Go to STREAM.
  - STREAM: `o_valid`=1; `o_ch`=index; `o_cnt`/`o_ovf` come from the shadow at index. On `o_valid`&`i_ready`: if index = CH_NUM−1, go to IDLE; else index+1.
- Counting continues in every state. Only the snapshot clears the live counters.
- Simultaneous edge and snapshot clear in the SNAP cycle: the shadow gets the pre-edge value and the live count becomes 1. No edge is lost or double counted.
- `i_snap` is ignored while `o_busy`=1.
- A snapshot taken with `i_en`=0 is legal.
- `o_valid` never drops without a handshake.
- Stream data is stable while `o_valid`&~`i_ready`.

## Timing
- Reset values:
  - all cnt, ovf, shadow and prev = 0
  - FSM = IDLE
  - index = 0
  - `o_busy`=0, `o_valid`=0, `o_ch`=0, `o_cnt`=0, `o_ovf`=0
- Reset mid-operation (counting or streaming) aborts immediately to the reset state. Partially streamed data is discarded.
- Edge-to-count latency is one clock: a pulse bit first sampled high at edge k (prev=0) gives cnt+1 visible after edge k.
- Snapshot timing:
  - `i_snap` sampled at edge k gives SNAP after edge k.
  - Capture and clear happen at edge k+1.
  - First `o_valid` is visible after edge k+1.
- Minimum stream length is CH_NUM cycles with `i_ready` held at 1.
- `o_busy` deasserts on the cycle after the final handshake.

## Configuration
- `PULSE_CNT_SYNC_EN` defined:
  - Each `i_pulse` bit passes through a two-flop synchroniser, reset to 0, before edge detection.
  - Edge-to-count latency becomes 3 clocks.
- Not defined:
  - `i_pulse` is sampled directly; the inputs must be synchronous to `i_clk`.
  - Latency is 1 clock.
- Counter, FSM and stream behaviour are otherwise identical in both builds.

## Structure
- Package `pulse_cnt_pkg`:
  - edge-mode constants EDGE_RISE/EDGE_FALL/EDGE_BOTH
  - FSM state typedef (IDLE/SNAP/STREAM)
  - CH_W width function
- Sub-module `pulse_edge_counter`: one channel, containing the optional synchroniser, prev register, edge select, cnt and ovf, with a clear input. It is instantiated CH_NUM times in a generate loop.
- The top level holds the shadow registers, FSM, index and output mux.

## Test plan
- Reset check: assert `i_rst` for 2 cycles → all outputs 0, `o_busy`=0; after release, 3 rising edges on ch0 → snapshot streams ch0 cnt=3 and every other channel 0.
- Edge modes: 4 full pulses on ch5 in mode 00, 01 and 10 → captured counts 4, 4 and 8.
- Boundary: CNT_W=4, 17 rising edges on ch1 → SATURATE=1 gives cnt=15, ovf=1; SATURATE=0 gives cnt=1, ovf=1.
- Simultaneous edge and snapshot: rising edge on ch2 in the SNAP cycle → shadow excludes it; the next snapshot reports ch2 cnt=1.
- Backpressure: toggle `i_ready` randomly; ch3 cnt=9 → words arrive in order ch0..CH_NUM−1, data stays stable while stalled, `i_snap` pulses during STREAM are ignored, and `o_busy` drops after the last handshake.
- Reset mid-stream: assert `i_rst` after 5 handshakes → `o_valid`=0, FSM in IDLE; a new snapshot returns all zeros.

Source files
------------

// File: rtl/pulse_cnt_pkg.sv
// Shared definitions for the pulse counter bank: edge-mode codes, FSM states, index width helper.
// No logic, no latency, no flow control.
package pulse_cnt_pkg;

   localparam logic [1:0] EDGE_RISE = 2'b00;
   localparam logic [1:0] EDGE_FALL = 2'b01;
   localparam logic [1:0] EDGE_BOTH = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SNAP   = 2'd1,
      STREAM = 2'd2
   } state_t;

   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pulse_edge_counter.sv
// One channel: optional 2-flop synchroniser (PULSE_CNT_SYNC_EN), edge select, counter and sticky overflow.
// Edge-to-count latency 1 clock (3 with the synchroniser); no backpressure, clear wins but keeps a coincident edge.
module pulse_edge_counter
   import pulse_cnt_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pulse,
   input  logic             i_en,
   input  logic [1:0]       i_edge_mode,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_ovf
);

   logic pulse_s;
   logic prev;
   logic hit;
   logic inc;

`ifdef PULSE_CNT_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) sync <= 2'b00;
      else       sync <= {sync[0], i_pulse};
   end
   assign pulse_s = sync[1];
`else
   assign pulse_s = i_pulse;
`endif

   always_comb begin
      hit = 1'b0;
      case (i_edge_mode)
         EDGE_FALL: hit = ~pulse_s & prev;
         EDGE_BOTH: hit = pulse_s ^ prev;
         default:   hit = pulse_s & ~prev;
      endcase
   end

   assign inc = hit & i_en;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prev  <= 1'b0;
         o_cnt <= '0;
         o_ovf <= 1'b0;
      end else begin
         prev <= pulse_s;
         // An edge landing on the clear cycle starts the new interval so it is never lost.
         if (i_clr) begin
            o_cnt <= {{(CNT_W-1){1'b0}}, inc};
            o_ovf <= 1'b0;
         end else if (inc) begin
            if (&o_cnt) begin
               o_ovf <= 1'b1;
               if (!SATURATE) o_cnt <= '0;
            end else begin
               o_cnt <= o_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pulse_counter_bank.sv
// Multi-channel edge counter bank with atomic snapshot/clear and a valid/ready readout stream, one channel per word.
// Snapshot: capture one clock after i_snap, first word the clock after; stream holds data while i_ready is low.
module pulse_counter_bank
   import pulse_cnt_pkg::*;
#(
   parameter int CH_NUM   = 16,
   parameter int CNT_W    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [CH_NUM-1:0]           i_pulse,
   input  logic                        i_en,
   input  logic [1:0]                  i_edge_mode,
   input  logic                        i_snap,
   output logic                        o_busy,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [ch_w(CH_NUM)-1:0]     o_ch,
   output logic [CNT_W-1:0]            o_cnt,
   output logic                        o_ovf
);

   localparam int CH_W = ch_w(CH_NUM);
   localparam logic [CH_W-1:0] LAST = CH_W'(CH_NUM - 1);

   logic [CNT_W-1:0] live_cnt   [CH_NUM];
   logic [CH_NUM-1:0] live_ovf;
   logic [CNT_W-1:0] shadow_cnt [CH_NUM];
   logic [CH_NUM-1:0] shadow_ovf;
   state_t           state;
   logic [CH_W-1:0]  idx;
   logic [CH_W-1:0]  nxt;
   logic             clr;

   assign clr  = (state == SNAP);
   assign nxt  = idx + CH_W'(1);
   assign o_ch = idx;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      pulse_edge_counter #(
         .CNT_W    (CNT_W),
         .SATURATE (SATURATE)
      ) u_cnt (
         .i_clk       (i_clk),
         .i_rst       (i_rst),
         .i_pulse     (i_pulse[g]),
         .i_en        (i_en),
         .i_edge_mode (i_edge_mode),
         .i_clr       (clr),
         .o_cnt       (live_cnt[g]),
         .o_ovf       (live_ovf[g])
      );
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         idx        <= '0;
         o_busy     <= 1'b0;
         o_valid    <= 1'b0;
         o_cnt      <= '0;
         o_ovf      <= 1'b0;
         shadow_ovf <= '0;
         for (int i = 0; i < CH_NUM; i++) shadow_cnt[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_snap) begin
                  state  <= SNAP;
                  o_busy <= 1'b1;
               end
            end
            SNAP: begin
               for (int i = 0; i < CH_NUM; i++) shadow_cnt[i] <= live_cnt[i];
               shadow_ovf <= live_ovf;
               idx        <= '0;
               // Word 0 comes straight from the live side since the shadow is only written this edge.
               o_cnt      <= live_cnt[0];
               o_ovf      <= live_ovf[0];
               o_valid    <= 1'b1;
               state      <= STREAM;
            end
            STREAM: begin
               if (i_ready) begin
                  if (idx == LAST) begin
                     state   <= IDLE;
                     idx     <= '0;
                     o_valid <= 1'b0;
                     o_busy  <= 1'b0;
                  end else begin
                     idx   <= nxt;
                     o_cnt <= shadow_cnt[nxt];
                     o_ovf <= shadow_ovf[nxt];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_counter_bank.sv
// Bench for pulse_counter_bank: a saturating and a wrapping instance share stimulus; a monitor scoreboards both streams.
module tb_pulse_counter_bank;

   localparam int CH_NUM = 8;
   localparam int CNT_W  = 4;
   localparam int CH_W   = 3;

   typedef struct packed {
      logic [CH_W-1:0]  ch;
      logic [CNT_W-1:0] cnt;
      logic             ovf;
   } word_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [CH_NUM-1:0] pulse;
   logic              en;
   logic [1:0]        mode;
   logic              snap;
   logic              ready;

   logic              busy0, valid0, ovf0;
   logic [CH_W-1:0]   ch0;
   logic [CNT_W-1:0]  cnt0;
   logic              busy1, valid1, ovf1;
   logic [CH_W-1:0]   ch1;
   logic [CNT_W-1:0]  cnt1;

   word_t q0[$];
   word_t q1[$];
   int    checks = 0;
   int    errors = 0;
   int    hs0    = 0;

   int    exp_cnt0 [CH_NUM];
   int    exp_cnt1 [CH_NUM];
   bit    exp_ovf0 [CH_NUM];
   bit    exp_ovf1 [CH_NUM];

   bit    stall [2];
   bit    endq  [2];
   word_t held  [2];

   always #5 clk = ~clk;

   pulse_counter_bank #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .SATURATE(1'b1)) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_en(en), .i_edge_mode(mode),
      .i_snap(snap), .o_busy(busy0), .o_valid(valid0), .i_ready(ready),
      .o_ch(ch0), .o_cnt(cnt0), .o_ovf(ovf0)
   );

   pulse_counter_bank #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .SATURATE(1'b0)) dut_wrap (
      .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_en(en), .i_edge_mode(mode),
      .i_snap(snap), .o_busy(busy1), .o_valid(valid1), .i_ready(ready),
      .o_ch(ch1), .o_cnt(cnt1), .o_ovf(ovf1)
   );

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mon_port(input int id, input logic busy, input logic valid,
                           input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] cnt, input logic ovf);
      word_t w;
      word_t e;
      bit    empty;
      w = '{ch: ch, cnt: cnt, ovf: ovf};
      if (rst) begin
         stall[id] = 1'b0;
         endq[id]  = 1'b0;
         return;
      end
      if (endq[id]) begin
         cmp($sformatf("busy_drop%0d", id), int'(busy), 0);
         endq[id] = 1'b0;
      end
      if (stall[id]) begin
         cmp($sformatf("stall_valid%0d", id), int'(valid), 1);
         cmp($sformatf("stall_data%0d", id), int'(w), int'(held[id]));
      end
      if (valid && ready) begin
         empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
         if (empty) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word%0d actual ch=%0d cnt=%0d required none", id, ch, cnt);
         end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            cmp($sformatf("ch%0d", id), int'(ch), int'(e.ch));
            cmp($sformatf("cnt%0d_ch%0d", id, e.ch), int'(cnt), int'(e.cnt));
            cmp($sformatf("ovf%0d_ch%0d", id, e.ch), int'(ovf), int'(e.ovf));
         end
         if (id == 0) hs0++;
         if (int'(ch) == CH_NUM - 1) endq[id] = 1'b1;
      end
      stall[id] = valid && !ready;
      held[id]  = w;
   endtask

   always @(negedge clk) begin
      mon_port(0, busy0, valid0, ch0, cnt0, ovf0);
      mon_port(1, busy1, valid1, ch1, cnt1, ovf1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_ch(input int ch, input int n);
      for (int i = 0; i < n; i++) begin
         pulse[ch] = 1'b1;
         tick();
         pulse[ch] = 1'b0;
         tick();
      end
   endtask

   task automatic push_exp();
      for (int c = 0; c < CH_NUM; c++) begin
         q0.push_back('{ch: CH_W'(c), cnt: CNT_W'(exp_cnt0[c]), ovf: exp_ovf0[c]});
         q1.push_back('{ch: CH_W'(c), cnt: CNT_W'(exp_cnt1[c]), ovf: exp_ovf1[c]});
         exp_cnt0[c] = 0; exp_cnt1[c] = 0;
         exp_ovf0[c] = 1'b0; exp_ovf1[c] = 1'b0;
      end
   endtask

   task automatic wait_stream(input bit rnd);
      bit done = 1'b0;
      for (int n = 0; n < 400 && !done; n++) begin
         if (!busy0 && !busy1 && q0.size() == 0 && q1.size() == 0) begin
            done = 1'b1;
         end else begin
            if (rnd) begin
               ready = 1'($urandom_range(0, 1));
               snap  = busy0 ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
               ready = 1'b1;
            end
            tick();
         end
      end
      snap  = 1'b0;
      ready = 1'b1;
      cmp("stream_done", int'(done), 1);
   endtask

   task automatic do_snap(input bit rnd);
      tick();
      push_exp();
      snap = 1'b1;
      tick();
      snap = 1'b0;
      wait_stream(rnd);
   endtask

   task automatic set_both(input int ch, input int c0, input bit o0, input int c1, input bit o1);
      exp_cnt0[ch] = c0; exp_ovf0[ch] = o0;
      exp_cnt1[ch] = c1; exp_ovf1[ch] = o1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int c = 0; c < CH_NUM; c++) set_both(c, 0, 1'b0, 0, 1'b0);
      rst = 1'b1; pulse = '0; en = 1'b1; mode = 2'b00; snap = 1'b0; ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      cmp("rst_busy0", int'(busy0), 0);   cmp("rst_valid0", int'(valid0), 0);
      cmp("rst_ch0", int'(ch0), 0);       cmp("rst_cnt0", int'(cnt0), 0);
      cmp("rst_ovf0", int'(ovf0), 0);     cmp("rst_busy1", int'(busy1), 0);
      cmp("rst_valid1", int'(valid1), 0); cmp("rst_cnt1", int'(cnt1), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      tick();

      // Three rising edges on ch0; edges with the enable low are not counted.
      pulse_ch(0, 3);
      en = 1'b0;
      pulse_ch(7, 3);
      en = 1'b1;
      set_both(0, 3, 1'b0, 3, 1'b0);
      do_snap(1'b0);

      // Edge modes on ch5.
      mode = 2'b00; pulse_ch(5, 4); set_both(5, 4, 1'b0, 4, 1'b0); do_snap(1'b0);
      mode = 2'b01; pulse_ch(5, 4); set_both(5, 4, 1'b0, 4, 1'b0); do_snap(1'b0);
      mode = 2'b10; pulse_ch(5, 4); set_both(5, 8, 1'b0, 8, 1'b0); do_snap(1'b0);
      mode = 2'b00;

      // 17 edges into a 4-bit counter: saturate at 15, wrap lands on 1.
      pulse_ch(1, 17);
      set_both(1, 15, 1'b1, 1, 1'b1);
      do_snap(1'b0);

      // Edge on ch2 coinciding with the capture edge belongs to the next interval.
      tick();
      push_exp();
      snap = 1'b1;
      tick();
      snap = 1'b0;
      pulse[2] = 1'b1;
      tick();
      pulse[2] = 1'b0;
      wait_stream(1'b0);
      set_both(2, 1, 1'b0, 1, 1'b0);
      do_snap(1'b0);

      // Random backpressure with ignored snapshot requests while busy.
      pulse_ch(3, 9);
      set_both(3, 9, 1'b0, 9, 1'b0);
      do_snap(1'b1);

      // Reset in the middle of a stream discards it and the live counts.
      pulse_ch(4, 2);
      set_both(4, 2, 1'b0, 2, 1'b0);
      tick();
      push_exp();
      hs0   = 0;
      ready = 1'b0;
      snap  = 1'b1;
      tick();
      snap  = 1'b0;
      pulse_ch(6, 1);
      ready = 1'b1;
      n = 0;
      while (hs0 < 5 && n < 100) begin
         tick();
         n++;
      end
      cmp("five_handshakes", hs0, 5);
      rst = 1'b1;
      tick();
      q0.delete();
      q1.delete();
      @(negedge clk);
      cmp("mid_rst_valid0", int'(valid0), 0); cmp("mid_rst_busy0", int'(busy0), 0);
      cmp("mid_rst_valid1", int'(valid1), 0); cmp("mid_rst_ch0", int'(ch0), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      tick();
      do_snap(1'b0);

      repeat (3) tick();
      cmp("q0_left", q0.size(), 0);
      cmp("q1_left", q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
